// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: LC-3b word/opcode types plus fetch FSM state and BR offset width.
package fetch_unit_pkg;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [3:0] {
    op_br = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb = 4'h3,
    op_jsr = 4'h4, op_and = 4'h5, op_ldr = 4'h6, op_str = 4'h7,
    op_rti = 4'h8, op_not = 4'h9, op_ldi = 4'ha, op_sti = 4'hb,
    op_jmp = 4'hc, op_shf = 4'hd, op_lea = 4'he, op_trap = 4'hf
  } lc3b_opcode;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
  localparam int BR_OFF_W = 9;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read/resp handshake between fetch (master) and memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  lc3b_word i_mem_address;
  logic i_mem_read;
  logic i_mem_resp;
  lc3b_word i_mem_rdata;
  modport master (output i_mem_address, i_mem_read, input i_mem_resp, i_mem_rdata);
  modport slave (input i_mem_address, i_mem_read, output i_mem_resp, i_mem_rdata);
endinterface

// File: rtl/fetch_predecode.sv
// fetch_predecode: flags conditional BR words (nzp!=000) and computes their taken target.
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  lc3b_word ir,
  input  lc3b_word pc,
  output logic     is_br,
  output lc3b_word target
);
  assign is_br = (lc3b_opcode'(ir[15:12]) == op_br) && (ir[11:9] != 3'b000);
  assign target = pc + 16'd2 + {{(16 - BR_OFF_W - 1){ir[BR_OFF_W-1]}}, ir[BR_OFF_W-1:0], 1'b0};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LC-3b IF stage with PC, imem handshake and one-entry fetch buffer.
// Define PRED_TARGET_EN to follow predicted-taken BR targets.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter lc3b_word PC_RESET = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_enable,
  input  logic          stall,
  input  logic          redirect,
  input  lc3b_word      redirect_pc,
  input  logic          predict_taken,
  fetch_unit_if.master  imem,
  output logic          br_instruction,
  output logic          if_valid,
  output lc3b_word      if_ir,
  output lc3b_word      if_pc,
  output logic          if_pred_taken
);
  fetch_state_t state_q, state_d;
  lc3b_word pc_q, pc_d, req_addr_q, req_addr_d, if_ir_q, if_ir_d, if_pc_q, if_pc_d;
  logic if_valid_q, if_valid_d, if_pred_q, if_pred_d;
  logic is_br, pred, consume;
  lc3b_word br_target, next_pc;

  fetch_predecode u_predecode (.ir(imem.i_mem_rdata), .pc(req_addr_q), .is_br(is_br), .target(br_target));

`ifdef PRED_TARGET_EN
  assign pred = is_br & predict_taken;
  assign next_pc = pred ? br_target : req_addr_q + 16'd2;
`else
  logic unused_pred;
  assign unused_pred = ^{predict_taken, br_target};
  assign pred = 1'b0;
  assign next_pc = req_addr_q + 16'd2;
`endif

  assign consume = if_valid_q & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_addr_d = req_addr_q;
    if_valid_d = if_valid_q & ~consume;
    if_ir_d = if_ir_q;
    if_pc_d = if_pc_q;
    if_pred_d = if_pred_q;
    case (state_q)
      IDLE: if (!redirect && fetch_enable && (!if_valid_q || consume)) begin
        state_d = REQ;
        req_addr_d = pc_q;
      end
      REQ: if (redirect) state_d = imem.i_mem_resp ? IDLE : DRAIN;
      else if (imem.i_mem_resp) begin
        state_d = IDLE;
        pc_d = next_pc;
        if_valid_d = 1'b1;
        if_ir_d = imem.i_mem_rdata;
        if_pc_d = req_addr_q;
        if_pred_d = pred;
      end
      DRAIN: state_d = imem.i_mem_resp ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    // redirect outranks consume and any in-flight buffer write
    if (redirect) begin
      pc_d = redirect_pc;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= PC_RESET;
      req_addr_q <= PC_RESET;
      if_valid_q <= 1'b0;
      if_ir_q <= '0;
      if_pc_q <= '0;
      if_pred_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_addr_q <= req_addr_d;
      if_valid_q <= if_valid_d;
      if_ir_q <= if_ir_d;
      if_pc_q <= if_pc_d;
      if_pred_q <= if_pred_d;
    end
  end

  assign imem.i_mem_read = state_q != IDLE;
  assign imem.i_mem_address = req_addr_q;
  assign br_instruction = imem.i_mem_resp & (state_q == REQ) & is_br;
  assign if_valid = if_valid_q;
  assign if_ir = if_ir_q;
  assign if_pc = if_pc_q;
  assign if_pred_taken = if_pred_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit sequencing, stall, redirect/drain, predecode and wrap.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset, fetch_enable, stall, redirect, predict_taken;
  logic [15:0] redirect_pc, mem_word;
  logic mem_auto, man_resp;
  logic br_instruction, if_valid, if_pred_taken;
  logic [15:0] if_ir, if_pc;
  int n_cmp = 0;
  int n_err = 0;

  fetch_unit_if bus();
  assign bus.i_mem_resp = (mem_auto & bus.i_mem_read) | man_resp;
  assign bus.i_mem_rdata = mem_word;

  fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .predict_taken(predict_taken),
    .imem(bus.master), .br_instruction(br_instruction), .if_valid(if_valid),
    .if_ir(if_ir), .if_pc(if_pc), .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; fetch_enable = 1; stall = 0; redirect = 0; redirect_pc = 0;
    predict_taken = 0; mem_auto = 1; man_resp = 0; mem_word = 16'h1234;
    step();
    chk("rst_read", 16'(bus.i_mem_read), 16'd0);
    chk("rst_valid", 16'(if_valid), 16'd0);
    chk("rst_ir", if_ir, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_pred", 16'(if_pred_taken), 16'd0);
    chk("rst_br", 16'(br_instruction), 16'd0);
    chk("rst_addr", bus.i_mem_address, 16'h0000);
    reset = 0;
    step();
    chk("req0_read", 16'(bus.i_mem_read), 16'd1);
    chk("req0_addr", bus.i_mem_address, 16'h0000);
    chk("req0_br", 16'(br_instruction), 16'd0);
    step();
    chk("buf0_read", 16'(bus.i_mem_read), 16'd0);
    chk("buf0_valid", 16'(if_valid), 16'd1);
    chk("buf0_pc", if_pc, 16'h0000);
    chk("buf0_ir", if_ir, 16'h1234);
    step();
    chk("req2_addr", bus.i_mem_address, 16'h0002);
    chk("req2_valid", 16'(if_valid), 16'd0);
    step();
    chk("buf2_pc", if_pc, 16'h0002);
    step();
    chk("req4_addr", bus.i_mem_address, 16'h0004);
    step();
    chk("buf4_pc", if_pc, 16'h0004);
    chk("buf4_valid", 16'(if_valid), 16'd1);
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 16'(if_valid), 16'd1);
      chk("stall_pc", if_pc, 16'h0004);
      chk("stall_ir", if_ir, 16'h1234);
      chk("stall_read", 16'(bus.i_mem_read), 16'd0);
    end
    stall = 0;
    step();
    chk("unstall_read", 16'(bus.i_mem_read), 16'd1);
    chk("unstall_addr", bus.i_mem_address, 16'h0006);
    chk("unstall_valid", 16'(if_valid), 16'd0);
    step();
    chk("buf6_pc", if_pc, 16'h0006);
    mem_auto = 0;
    step();
    chk("req8_addr", bus.i_mem_address, 16'h0008);
    step();
    chk("hold_read", 16'(bus.i_mem_read), 16'd1);
    chk("hold_addr", bus.i_mem_address, 16'h0008);
    redirect = 1; redirect_pc = 16'h4000;
    step();
    redirect = 0;
    chk("drain_read", 16'(bus.i_mem_read), 16'd1);
    chk("drain_addr", bus.i_mem_address, 16'h0008);
    chk("drain_valid", 16'(if_valid), 16'd0);
    step();
    chk("drain2_addr", bus.i_mem_address, 16'h0008);
    mem_word = 16'h0E05; man_resp = 1;
    #1;
    chk("drain_br", 16'(br_instruction), 16'd0);
    step();
    man_resp = 0; mem_word = 16'h1234;
    chk("drained_read", 16'(bus.i_mem_read), 16'd0);
    chk("drained_valid", 16'(if_valid), 16'd0);
    step();
    chk("req4000_addr", bus.i_mem_address, 16'h4000);
    chk("req4000_read", 16'(bus.i_mem_read), 16'd1);
    redirect = 1; redirect_pc = 16'h0100; man_resp = 1;
    step();
    redirect = 0; man_resp = 0;
    chk("rdr_resp_valid", 16'(if_valid), 16'd0);
    chk("rdr_resp_read", 16'(bus.i_mem_read), 16'd0);
    step();
    chk("req100_addr", bus.i_mem_address, 16'h0100);
    mem_auto = 1;
    step();
    chk("buf100_valid", 16'(if_valid), 16'd1);
    chk("buf100_pc", if_pc, 16'h0100);
    redirect = 1; redirect_pc = 16'h0010;
    step();
    redirect = 0;
    chk("rdr_idle_valid", 16'(if_valid), 16'd0);
    chk("rdr_idle_read", 16'(bus.i_mem_read), 16'd0);
    step();
    chk("req10_addr", bus.i_mem_address, 16'h0010);
    mem_word = 16'h0E05; predict_taken = 1;
    #1;
    chk("br_flag", 16'(br_instruction), 16'd1);
    step();
    chk("br_ir", if_ir, 16'h0E05);
    chk("br_pc", if_pc, 16'h0010);
`ifdef PRED_TARGET_EN
    chk("br_pred", 16'(if_pred_taken), 16'd1);
`else
    chk("br_pred", 16'(if_pred_taken), 16'd0);
`endif
    predict_taken = 0; mem_word = 16'h1234;
    step();
`ifdef PRED_TARGET_EN
    chk("br_next_addr", bus.i_mem_address, 16'h001C);
`else
    chk("br_next_addr", bus.i_mem_address, 16'h0012);
`endif
    step();
    chk("after_br_pred", 16'(if_pred_taken), 16'd0);
    redirect = 1; redirect_pc = 16'hFFFE;
    step();
    redirect = 0;
    step();
    chk("reqfffe_addr", bus.i_mem_address, 16'hFFFE);
    step();
    chk("buffffe_pc", if_pc, 16'hFFFE);
    step();
    chk("wrap_addr", bus.i_mem_address, 16'h0000);
    chk("wrap_read", 16'(bus.i_mem_read), 16'd1);
    reset = 1;
    step();
    reset = 0;
    chk("midrst_read", 16'(bus.i_mem_read), 16'd0);
    chk("midrst_valid", 16'(if_valid), 16'd0);
    chk("midrst_addr", bus.i_mem_address, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
